// File: rtl/prbs31_checker.sv
// PRBS31 (x^31+x^28+1) receive checker: self-syncs to the serial stream, flags lock and counts errors while locked.
// Optional macro PRBS31_CHK_INV_EN adds inv_in to accept an inverted-polarity link.
module prbs31_checker #(
  parameter int LOCK_CNT    = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
`ifdef PRBS31_CHK_INV_EN
  input  logic             inv_in,
`endif
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [30:0]      sr, sr_nxt;
  logic [4:0]       fill, fill_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic [BAD_W-1:0] bad, bad_nxt;
  logic             rx, pred, mismatch;
  logic             err_hit, locked_nxt;
  logic [ERR_W-1:0] cnt_nxt;

`ifdef PRBS31_CHK_INV_EN
  assign rx = bit_in ^ inv_in;
`else
  assign rx = bit_in;
`endif
  assign pred     = sr[30] ^ sr[27];
  assign mismatch = rx ^ pred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sr        <= '0;
      fill      <= '0;
      run       <= '0;
      bad       <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      fill      <= fill_nxt;
      run       <= run_nxt;
      bad       <= bad_nxt;
      locked    <= locked_nxt;
      err_pulse <= err_hit;
      err_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    fill_nxt  = fill;
    run_nxt   = run;
    bad_nxt   = bad;
    if (bit_valid) begin
      unique case (state)
        HUNT: begin
          sr_nxt = {sr[29:0], rx};
          // An all-zero register is the LFSR lock-up state, so keep re-testing until a one arrives
          if (fill >= 5'd30) begin
            fill_nxt = 5'd31;
            if (sr_nxt != '0) begin
              state_nxt = VERIFY;
              run_nxt   = '0;
            end
          end else begin
            fill_nxt = fill + 5'd1;
          end
        end
        VERIFY: begin
          sr_nxt = {sr[29:0], rx};
          if (mismatch) begin
            state_nxt = HUNT;
            fill_nxt  = '0;
          end else begin
            run_nxt = run + RUN_W'(1);
            if (run_nxt == RUN_W'(LOCK_CNT)) state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a received error never corrupts the reference
          sr_nxt = {sr[29:0], pred};
          if (mismatch) begin
            bad_nxt = bad + BAD_W'(1);
            if (bad_nxt == BAD_W'(LOSS_THRESH)) begin
              state_nxt = HUNT;
              fill_nxt  = '0;
              bad_nxt   = '0;
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    err_hit    = bit_valid && (state == LOCKED) && mismatch;
    locked_nxt = (state_nxt == LOCKED);
    cnt_nxt    = clear_cnt ? '0 : err_count;
    if (err_hit && !(&cnt_nxt)) cnt_nxt = cnt_nxt + ERR_W'(1);
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: lock latency, gated beats, error counting, loss of lock, saturation.
module tb_prbs31_checker;

  localparam logic [30:0] SEED = 31'h7FFF_FFFF;

  logic       clk = 1'b0;
  logic       rst_n, rst4_n;
  logic       bit_in, bit_valid, clear_cnt;
`ifdef PRBS31_CHK_INV_EN
  logic       inv_in;
`endif
  logic       locked, err_pulse;
  logic [15:0] err_count;
  logic       locked4, err_pulse4;
  logic [3:0] err_count4;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic locked_seen;
  logic [30:0] g;

  always #5 clk = ~clk;

  prbs31_checker dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
`ifdef PRBS31_CHK_INV_EN
    .inv_in(inv_in),
`endif
    .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs31_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .bit_in(bit_in), .bit_valid(bit_valid),
`ifdef PRBS31_CHK_INV_EN
    .inv_in(inv_in),
`endif
    .clear_cnt(clear_cnt), .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference generator: b[n] = b[n-31] ^ b[n-28]
  function automatic logic gen_bit();
    logic nb;
    nb = g[30] ^ g[27];
    g  = {g[29:0], nb};
    return nb;
  endfunction

  task automatic drive(input logic b, input logic v, input logic clr);
    bit_in    = b;
    bit_valid = v;
    clear_cnt = clr;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    if (err_pulse) pulses++;
    if (locked) locked_seen = 1'b1;
  endtask

  task automatic send(input int n, input logic flip, input logic alt);
    for (int i = 0; i < n; i++) begin
      drive(gen_bit() ^ flip, 1'b1, 1'b0);
      if (alt) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; clear_cnt = 1'b0;
`ifdef PRBS31_CHK_INV_EN
    inv_in = 1'b0;
`endif
    locked_seen = 1'b0;

    // Reset held 3 cycles
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_locked", 32'(locked), 0);
      check("rst_pulse", 32'(err_pulse), 0);
      check("rst_count", 32'(err_count), 0);
    end
    rst_n = 1'b1;

    // Clean continuous stream: lock visible right after beat 95
    g = SEED;
    send(94, 1'b0, 1'b0);
    check("lock_beat94", 32'(locked), 0);
    send(1, 1'b0, 1'b0);
    check("lock_beat95", 32'(locked), 1);
    pulses = 0;
    send(1905, 1'b0, 1'b0);
    check("clean_count", 32'(err_count), 0);
    check("clean_pulses", 32'(pulses), 0);
    check("clean_locked", 32'(locked), 1);

    // Alternate-cycle beats: 95th beat lands at cycle 189, lock read at 190
    reset_dut();
    g = SEED;
    send(94, 1'b0, 1'b1);
    check("alt_beat94", 32'(locked), 0);
    send(1, 1'b0, 1'b0);
    check("alt_beat95", 32'(locked), 1);
    drive(1'b0, 1'b0, 1'b0);
    check("alt_hold", 32'(locked), 1);
    check("alt_count", 32'(err_count), 0);

    // Single inverted bit while locked
    send(20, 1'b0, 1'b0);
    send(1, 1'b1, 1'b0);
    check("one_err_pulse", 32'(err_pulse), 1);
    check("one_err_count", 32'(err_count), 1);
    check("one_err_locked", 32'(locked), 1);
    send(1, 1'b0, 1'b0);
    check("one_err_pulse_off", 32'(err_pulse), 0);
    pulses = 0;
    send(500, 1'b0, 1'b0);
    check("post_err_pulses", 32'(pulses), 0);
    check("post_err_count", 32'(err_count), 1);
    check("post_err_locked", 32'(locked), 1);

    // Clear on an idle cycle, then 8 consecutive errors drop lock
    drive(1'b0, 1'b0, 1'b1);
    check("clear_idle", 32'(err_count), 0);
    check("clear_keeps_lock", 32'(locked), 1);
    send(7, 1'b1, 1'b0);
    check("loss_after7", 32'(locked), 1);
    check("count_after7", 32'(err_count), 7);
    send(1, 1'b1, 1'b0);
    check("loss_after8", 32'(locked), 0);
    check("count_after8", 32'(err_count), 8);
    check("pulse_after8", 32'(err_pulse), 1);
    send(94, 1'b0, 1'b0);
    check("relock_beat94", 32'(locked), 0);
    send(1, 1'b0, 1'b0);
    check("relock_beat95", 32'(locked), 1);
    check("relock_count", 32'(err_count), 8);

    // Asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    check("async_locked", 32'(locked), 0);
    check("async_count", 32'(err_count), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // All-zero input never locks
    locked_seen = 1'b0;
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 1'b0);
    check("zeros_locked", 32'(locked_seen), 0);
    check("zeros_count", 32'(err_count), 0);

    // Error during VERIFY restarts the hunt and is not counted
    reset_dut();
    g = SEED;
    send(40, 1'b0, 1'b0);
    pulses = 0;
    send(1, 1'b1, 1'b0);
    check("verify_err_pulse", 32'(err_pulse), 0);
    check("verify_err_count", 32'(err_count), 0);
    send(94, 1'b0, 1'b0);
    check("verify_relock94", 32'(locked), 0);
    send(1, 1'b0, 1'b0);
    check("verify_relock95", 32'(locked), 1);
    check("verify_pulses", 32'(pulses), 0);

    // Narrow counter instance: clear ordering and saturation
    rst_n = 1'b0;
    rst4_n = 1'b1;
    g = SEED;
    send(95, 1'b0, 1'b0);
    check("w4_locked", 32'(locked4), 1);
    send(1, 1'b1, 1'b0); send(1, 1'b0, 1'b0);
    send(1, 1'b1, 1'b0); send(1, 1'b0, 1'b0);
    check("w4_count2", 32'(err_count4), 2);
    drive(gen_bit(), 1'b1, 1'b1);
    check("w4_clear_clean", 32'(err_count4), 0);
    send(1, 1'b1, 1'b0); send(1, 1'b0, 1'b0);
    send(1, 1'b1, 1'b0); send(1, 1'b0, 1'b0);
    drive(~gen_bit(), 1'b1, 1'b1);
    check("w4_clear_err_count", 32'(err_count4), 1);
    check("w4_clear_err_pulse", 32'(err_pulse4), 1);
    drive(1'b0, 1'b0, 1'b0);
    check("w4_idle_pulse", 32'(err_pulse4), 0);
    check("w4_idle_count", 32'(err_count4), 1);
    for (int i = 0; i < 20; i++) begin
      send(1, 1'b1, 1'b0);
      check("w4_sat_pulse", 32'(err_pulse4), 1);
      check("w4_sat_count", 32'(err_count4), (i + 2 > 15) ? 15 : i + 2);
      send(1, 1'b0, 1'b0);
    end
    check("w4_sat_locked", 32'(locked4), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Downstream receive stage for the PRBS31 pattern generator in the tt_um_JONATHANEC1105_prbs31 design.
- Consumes a serial bit stream with a per-bit valid qualifier.
- Self-synchronises to the x^31+x^28+1 sequence and reports lock status.
- Counts bit errors while locked; the count drives status pins in the top level.

Parameters:
- LOCK_CNT, 64: consecutive correct predicted bits required in VERIFY before declaring lock.
- LOSS_THRESH, 8: consecutive errored bits in LOCKED that force loss of lock.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  the single clock; all logic is on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- bit_in  input  1  received serial data bit.
- bit_valid  input  1  bit_in is a new bit this cycle (a "beat").
- clear_cnt  input  1  synchronous clear of err_count.
- locked  output  1  checker is locked to the sequence.
- err_pulse  output  1  one-cycle flag: previous beat was in error while locked.
- err_count  output  ERR_W  saturating count of errored bits while locked.

Behaviour:
- Reset: the asynchronous assert of rst_n clears everything.
  - Outputs go to 0: locked=0, err_pulse=0, err_count=0.
  - Internal state clears: shift register sr[30:0]=0, FSM=HUNT, fill/run/bad counters=0.
- Only beats (bit_valid=1) advance sr, the FSM and the counters. With bit_valid=0 all state holds and err_pulse=0.
- Prediction: pred = sr[30] ^ sr[27]. sr shifts left, and the shift-in bit enters sr[0].
- FSM state HUNT:
  - Each beat shifts bit_in into sr; fill counts 0..31.
  - When fill reaches 31: if sr is non-zero, go to VERIFY with run=0. If sr is all-zero, stay in HUNT with fill=31 and keep re-testing each beat.
- FSM state VERIFY:
  - Each beat compares bit_in to pred, then shifts bit_in into sr.
  - Match: run+1. When run reaches LOCK_CNT, go to LOCKED.
  - Mismatch: go to HUNT with fill=0. sr keeps its contents.
- FSM state LOCKED:
  - Each beat shifts pred, not bit_in, into sr. This self-runs the generator, so a single received error does not propagate.
  - Mismatch: err_pulse=1 on the next cycle, err_count+1 (saturating at all-ones), bad+1.
  - Match: bad=0.
  - When bad reaches LOSS_THRESH, go to HUNT with fill=0 and bad=0, and locked drops.
- locked is registered: it reads 1 starting the cycle after the beat that completes LOCK_CNT, and 0 starting the cycle after the LOSS_THRESH-th consecutive error.
- err_pulse and err_count update one cycle after the errored beat.
- Minimum lock latency from reset on a clean stream: 31+LOCK_CNT beats, plus 1 cycle.
- clear_cnt:
  - clear_cnt with no error in the same cycle gives err_count=0.
  - clear_cnt together with an errored beat gives err_count=1 (clear, then count).
  - clear_cnt does not affect lock state.
- Errors in HUNT or VERIFY are never counted and never pulse err_pulse.
- Saturation: at all-ones, err_count holds; err_pulse still fires.
- Reset mid-operation: immediate return to reset values; no partial state is retained.

Optional Feature:
- Macro: PRBS31_CHK_INV_EN.
- Defined:
  - Adds input port inv_in (1 bit, placed after bit_valid).
  - The checker uses bit_in ^ inv_in everywhere, allowing an inverted-polarity link to lock and count normally.
- Undefined:
  - Port absent; bit_in is used directly.
  - Otherwise identical timing.

Test Plan:
- Reset with rst_n held low for 3 cycles, then released -> locked=0, err_pulse=0, err_count=0 on every cycle.
- Clean PRBS31 stream seeded 0x7FFFFFFF with bit_valid=1 every cycle -> locked rises exactly 96 cycles after the first beat (31+64 beats plus 1 register cycle); err_count=0 after 2000 beats.
- Same clean stream with bit_valid low on alternate cycles -> locked rises after 95 beats, at cycle 190; no errors counted.
- Locked stream, one bit inverted -> exactly one err_pulse, err_count=1, locked stays 1; the next 500 beats produce no errors.
- Locked stream, 8 consecutive bits inverted -> err_count=8, locked falls the cycle after the 8th errored beat; clean stream afterwards -> re-lock after 95 beats.
- 300 beats of all-zero input -> locked never asserts.
- ERR_W=4, clear_cnt pulsed on the same beat as an error -> err_count=1; 20 further isolated errors -> err_count saturates at 15, err_pulse still fires each time.
